fifo_word_packer: RTL and testbench

//  Read-side consumer for the narrow synchronous FIFO.
//  - Pops WIDTH-bit entries one at a time through the FIFO read port.
//  - Packs WORDS consecutive entries into one WIDTH*WORDS output word.
//  - Presents each packed word on a valid/ready stream for downstream logic.
//  - Sits between the FIFO read port and any byte-wide or word-wide sink.

---
 rtl/fifo_word_packer_if.sv | 51 +++++
 rtl/fifo_word_packer.sv | 97 +++++++++
 tb/tb_fifo_word_packer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_packer_if.sv
// Interface bundling the FIFO read port and the packed-word output stream
// of fifo_word_packer. The optional out_parity signal exists only when
// FIFO_PACKER_PARITY_EN is defined.
//   master : the packer (drives fifo_rd_en and the out_* stream)
//   slave  : the surroundings (FIFO read side and downstream sink)
interface fifo_word_packer_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned WORDS = 8
);
    localparam int unsigned CW = $clog2(WORDS + 1);

    logic                     fifo_empty;
    logic [WIDTH-1:0]         fifo_data;
    logic                     fifo_rd_en;
    logic                     flush;
    logic [WIDTH*WORDS-1:0]   out_data;
    logic [CW-1:0]            out_count;
    logic                     out_valid;
    logic                     out_ready;
`ifdef FIFO_PACKER_PARITY_EN
    logic                     out_parity;
`endif

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        input  flush,
        output out_data,
        output out_count,
        output out_valid,
`ifdef FIFO_PACKER_PARITY_EN
        output out_parity,
`endif
        input  out_ready
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        output flush,
        input  out_data,
        input  out_count,
        input  out_valid,
`ifdef FIFO_PACKER_PARITY_EN
        input  out_parity,
`endif
        output out_ready
    );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops WIDTH-bit entries from a synchronous FIFO and packs
// WORDS of them (first popped in the LSBs) into one word presented on a
// valid/ready stream. A level flush emits a partial word once the FIFO is
// empty. Optional feature macro: FIFO_PACKER_PARITY_EN adds out_parity.
module fifo_word_packer #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned WORDS = 8
) (
    input  logic               clk,
    input  logic               reset,
    fifo_word_packer_if.master bus
);
    localparam int unsigned CW = $clog2(WORDS + 1);
    localparam int unsigned OW = WIDTH * WORDS;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   shreg_q, shreg_d;

    // State, entry count and shift register; async active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state: alternate FILL (issue read) and CAPTURE (store data),
    // so the FIFO's empty flag is current before every read
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        case (state_q)
            FILL: begin
                if (bus.fifo_empty && bus.flush && (cnt_q != '0)) begin
                    state_d = HOLD;
                end else if (!bus.fifo_empty) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        shreg_d[i*WIDTH +: WIDTH] = bus.fifo_data;
                    end
                end
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WORDS - 1)) ? HOLD : FILL;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // The reset level gates the read enable so no pop can be issued
    // while reset is held, even though FILL is the reset state
    assign bus.fifo_rd_en = reset && (state_q == FILL) && !bus.fifo_empty;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_count  = (state_q == HOLD) ? cnt_q : '0;
    assign bus.out_data   = shreg_q;

`ifdef FIFO_PACKER_PARITY_EN
    logic parity_q;

    // Parity registered alongside the shift register so it tracks out_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^shreg_d;
        end
    end

    assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed self-checking bench for fifo_word_packer (WIDTH=1, WORDS=8) with
// a simple FIFO model feeding the read port.
module tb_fifo_word_packer;
    logic clk;
    logic reset;

    fifo_word_packer_if #(.WIDTH(1), .WORDS(8)) bus ();

    fifo_word_packer #(.WIDTH(1), .WORDS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: entries pushed by the stimulus, popped on rd_en
    logic mem [64];
    int   wr_ptr;
    int   rd_ptr;
    logic data_q;
    int   rd_pulses;
    int   underflow;
    int   b2b;
    logic prev_rd;

    // Random-drive mode used while reset is held
    logic rnd_mode;
    logic rnd_empty;
    logic rnd_data;

    assign bus.fifo_empty = rnd_mode ? rnd_empty : (rd_ptr == wr_ptr);
    assign bus.fifo_data  = rnd_mode ? rnd_data  : data_q;

    initial begin
        rd_ptr    = 0;
        data_q    = 1'b0;
        rd_pulses = 0;
        underflow = 0;
        b2b       = 0;
        prev_rd   = 1'b0;
    end

    // Pop on read enable; track underflow and reads in adjacent cycles
    always @(posedge clk) begin
        prev_rd <= bus.fifo_rd_en;
        if (bus.fifo_rd_en) begin
            if (rd_ptr == wr_ptr) underflow <= underflow + 1;
            data_q    <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
            rd_pulses <= rd_pulses + 1;
            if (prev_rd) b2b <= b2b + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("valid_timeout", {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check("accept_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        int base;

        reset         = 1'b0;
        rnd_mode      = 1'b1;
        rnd_empty     = 1'b0;
        rnd_data      = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        wr_ptr        = 0;

        // 1: reset held with random inputs
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rnd_empty     = 1'($urandom_range(0, 1));
            rnd_data      = 1'($urandom_range(0, 1));
            bus.flush     = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_data",  {24'd0, bus.out_data},  32'd0);
            check("rst_count", {28'd0, bus.out_count}, 32'd0);
            check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
            check("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
        end
        rnd_mode      = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("idle_rd_en_empty", {31'd0, bus.fifo_rd_en}, 32'd0);

        // 2: full word 1,0,1,1,0,0,1,0 -> 8'h4D
        push(1); push(0); push(1); push(1); push(0); push(0); push(1); push(0);
        #1;
        check("fill_rd_en_follows", {31'd0, bus.fifo_rd_en}, 32'd1);
        base = rd_pulses;
        wait_valid(40, cyc);
        check("full_latency", cyc, 32'd16);
        check("full_rd_pulses", rd_pulses - base, 32'd8);
        check("full_data",  {24'd0, bus.out_data},  32'h4D);
        check("full_count", {28'd0, bus.out_count}, 32'd8);
`ifdef FIFO_PACKER_PARITY_EN
        check("full_parity", {31'd0, bus.out_parity}, 32'd0);
`endif

        // 3: hold with backpressure while FIFO has data (1,1,1,0,0,0,0,1)
        push(1); push(1); push(1); push(0); push(0); push(0); push(0); push(1);
        #1;
        base = rd_pulses;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_data",  {24'd0, bus.out_data},  32'h4D);
            check("hold_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
            @(negedge clk);
        end
        check("hold_no_pops", rd_pulses - base, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        check("release_valid", {31'd0, bus.out_valid}, 32'd0);
        check("release_count", {28'd0, bus.out_count}, 32'd0);
        check("refill_rd_en",  {31'd0, bus.fifo_rd_en}, 32'd1);
        wait_valid(40, cyc);
        check("refill_latency", cyc, 32'd16);
        check("refill_data",  {24'd0, bus.out_data},  32'h87);
        check("refill_count", {28'd0, bus.out_count}, 32'd8);
        accept();

        // 4: partial word via flush (1,1,0 then empty)
        push(1); push(1); push(0);
        bus.flush = 1'b1;
        wait_valid(40, cyc);
        check("flush_data",  {24'd0, bus.out_data},  32'h03);
        check("flush_count", {28'd0, bus.out_count}, 32'd3);
        accept();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_cnt0_valid", {31'd0, bus.out_valid}, 32'd0);
            check("flush_cnt0_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
        end
        bus.flush = 1'b0;

        // 5: FIFO empty for 6 cycles at cnt=4 (0,1,0,1 | 1,1,0,0 -> 8'h3A)
        push(0); push(1); push(0); push(1);
        base = rd_pulses;
        repeat (8) @(negedge clk);
        check("gap_first_pops", rd_pulses - base, 32'd4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("gap_rd_en",  {31'd0, bus.fifo_rd_en}, 32'd0);
            check("gap_valid",  {31'd0, bus.out_valid},  32'd0);
        end
        check("gap_no_pops", rd_pulses - base, 32'd4);
        push(1); push(1); push(0); push(0);
        wait_valid(40, cyc);
        check("gap_data",  {24'd0, bus.out_data},  32'h3A);
        check("gap_count", {28'd0, bus.out_count}, 32'd8);
        accept();

        // 6: reset during CAPTURE at cnt=5
        push(1); push(1); push(1); push(1); push(1); push(1); push(1); push(1);
        repeat (11) @(negedge clk);
        check("pre_reset_data", {24'd0, bus.out_data}, 32'h1F);
        reset = 1'b0;
        #1;
        check("midrst_data",  {24'd0, bus.out_data},  32'd0);
        check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push(0); push(0); push(0); push(0); push(0); push(0);
        wait_valid(40, cyc);
        check("postrst_data",  {24'd0, bus.out_data},  32'h03);
        check("postrst_count", {28'd0, bus.out_count}, 32'd8);
        accept();

        check("no_underflow", underflow, 32'd0);
        check("no_back_to_back_reads", b2b, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
